// File: rtl/lsu_bus_if_if.sv
// Word-addressed memory bus between the load/store unit and memory.
// The LSU is the master; the memory side acknowledges each request.
interface lsu_bus_if_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/lsu_bus_if.sv
// Load/store unit bus adapter: RV32I load/store formatting onto a single-outstanding
// word bus, sequenced by an IDLE/BUSY/DONE handshake FSM.
module lsu_bus_if (
  input  logic         clk,
  input  logic         rst,
  input  logic         rd_en,
  input  logic         wr_en,
  input  logic [2:0]   func3,
  input  logic [31:0]  addr,
  input  logic [31:0]  wdata,
  output logic [31:0]  rdata,
  output logic         load_valid,
  output logic         stall,
  output logic         lsu_err,
  lsu_bus_if_if.master bus
);
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;

  logic              is_load, is_store, fmt_ok, aligned, req_ok;
  logic              accept, err_c, stall_c, vld_p2;
  logic              we_p1;
  logic [DATA_W-1:0] addr_p1, wdata_p1, rdata_p2;
  logic [3:0]        be_p1;
  logic [2:0]        func3_p1;
  logic [1:0]        off_p1;

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   lane_be = 4'b0001 << off;
      2'b01:   lane_be = 4'b0011 << {off[1], 1'b0};
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] lane_wdata(input logic [2:0] f3,
                                                   input logic [DATA_W-1:0] wd);
    case (f3[1:0])
      2'b00:   lane_wdata = {4{wd[7:0]}};
      2'b01:   lane_wdata = {2{wd[15:0]}};
      default: lane_wdata = wd;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [DATA_W-1:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  fmt_load = DATA_W'(b);
      3'b100:  fmt_load = DATA_W'($unsigned(b));
      3'b001:  fmt_load = DATA_W'(h);
      3'b101:  fmt_load = DATA_W'($unsigned(h));
      default: fmt_load = word;
    endcase
  endfunction

  // Request legality: exactly one of rd_en/wr_en, a defined size code, natural alignment
  always_comb begin
    is_load  = rd_en & ~wr_en;
    is_store = wr_en & ~rd_en;
    fmt_ok   = is_load ? (func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                       : (is_store & (func3 inside {3'b000, 3'b001, 3'b010}));
    case (func3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    req_ok = fmt_ok & aligned;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    err_c     = 1'b0;
    stall_c   = 1'b0;
    case (state)
      IDLE: begin
        if (req_ok) begin
          accept    = 1'b1;
          stall_c   = 1'b1;
          state_nxt = BUSY;
        end else if (rd_en | wr_en) begin
          err_c = 1'b1;
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (bus.bus_ack) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Stage p1: accepted access; stage p2: formatted load result
  always_ff @(posedge clk) begin
    if (rst) begin
      we_p1    <= 1'b0;
      addr_p1  <= '0;
      be_p1    <= '0;
      wdata_p1 <= '0;
      func3_p1 <= '0;
      off_p1   <= '0;
      rdata_p2 <= '0;
    end else begin
      if (accept) begin
        we_p1    <= wr_en;
        addr_p1  <= {addr[31:2], 2'b00};
        be_p1    <= lane_be(func3, addr[1:0]);
        wdata_p1 <= lane_wdata(func3, wdata);
        func3_p1 <= func3;
        off_p1   <= addr[1:0];
      end
      if (state == BUSY && bus.bus_ack && !we_p1)
        rdata_p2 <= fmt_load(func3_p1, off_p1, bus.bus_rdata);
    end
  end

  assign vld_p2 = (state == DONE) & ~we_p1;

  // Reset forces every output quiet in the same cycle, even mid-access
  assign stall         = ~rst & stall_c;
  assign lsu_err       = ~rst & err_c;
  assign load_valid    = ~rst & vld_p2;
  assign rdata         = rst ? '0 : rdata_p2;
  assign bus.bus_req   = ~rst & (state == BUSY);
  assign bus.bus_we    = ~rst & we_p1;
  assign bus.bus_addr  = rst ? '0 : addr_p1;
  assign bus.bus_be    = rst ? '0 : be_p1;
  assign bus.bus_wdata = rst ? '0 : wdata_p1;
endmodule

// File: tb/tb_lsu_bus_if.sv
// Bench for lsu_bus_if: directed accesses, a transaction-level reference model
// compared every cycle, and literal expectations for the key scenarios.
module tb_lsu_bus_if;
  logic        clk = 1'b0;
  logic        rst, rd_en, wr_en;
  logic [2:0]  func3;
  logic [31:0] addr, wdata, rdata;
  logic        load_valid, stall, lsu_err;
  int          n_total = 0;
  int          n_pass  = 0;
  byte         ev[$];

  lsu_bus_if_if bif();

  lsu_bus_if dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .func3(func3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .load_valid(load_valid),
    .stall(stall), .lsu_err(lsu_err), .bus(bif)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference rules, written from the ISA view of sizes in bytes
  function automatic bit mf_legal(input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] a);
    int nb;
    if (rd == wr) return 1'b0;
    nb = 1 << f3[1:0];
    if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    if (wr && f3 > 3'd2) return 1'b0;
    return (a % nb) == 0;
  endfunction

  function automatic logic [3:0] mf_be(input logic [2:0] f3, input logic [31:0] a);
    int nb;
    nb = 1 << f3[1:0];
    return 4'(((1 << nb) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] mf_wd(input logic [2:0] f3, input logic [31:0] wd);
    if (f3[1:0] == 2'd0) return wd[7:0] * 32'h0101_0101;
    if (f3[1:0] == 2'd1) return wd[15:0] * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] mf_load(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] w);
    int          nb;
    logic [31:0] mask, v;
    nb   = 1 << f3[1:0];
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 1);
    v    = (w >> (8 * (a % 4))) & mask;
    if (!f3[2] && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
    return v;
  endfunction

  // Model state: one outstanding access, then one completion cycle
  bit          m_pend, m_fin, m_we, m_wd_known;
  logic [2:0]  m_f3;
  logic [31:0] m_a, m_addr, m_wd, m_rdata;
  logic [3:0]  m_be;

  always @(posedge clk) begin
    if (rst) begin
      m_pend <= 1'b0; m_fin <= 1'b0; m_we <= 1'b0; m_addr <= '0; m_be <= '0;
      m_wd <= '0; m_wd_known <= 1'b1; m_rdata <= '0;
    end else if (m_fin) begin
      m_fin <= 1'b0;
    end else if (m_pend) begin
      if (bif.bus_ack) begin
        m_pend <= 1'b0;
        m_fin  <= 1'b1;
        if (!m_we) m_rdata <= mf_load(m_f3, m_a, bif.bus_rdata);
      end
    end else if (mf_legal(rd_en, wr_en, func3, addr)) begin
      m_pend <= 1'b1; m_we <= wr_en; m_f3 <= func3; m_a <= addr;
      m_addr <= addr & ~32'd3; m_be <= mf_be(func3, addr);
      m_wd <= mf_wd(func3, wdata); m_wd_known <= wr_en;
    end
  end

  always @(negedge clk) begin
    bit leg, idle;
    idle = !m_pend && !m_fin;
    leg  = idle && mf_legal(rd_en, wr_en, func3, addr);
    if (load_valid) ev.push_back("L");
    if (bif.bus_req && bif.bus_we && bif.bus_ack) ev.push_back("W");
    if (rst) begin
      check("rst_stall", stall, 0);      check("rst_bus_req", bif.bus_req, 0);
      check("rst_load_valid", load_valid, 0); check("rst_lsu_err", lsu_err, 0);
      check("rst_rdata", rdata, 0);      check("rst_bus_we", bif.bus_we, 0);
      check("rst_bus_addr", bif.bus_addr, 0); check("rst_bus_be", bif.bus_be, 0);
      check("rst_bus_wdata", bif.bus_wdata, 0);
    end else begin
      check("stall", stall, m_pend || leg);
      check("lsu_err", lsu_err, idle && (rd_en || wr_en) && !leg);
      check("bus_req", bif.bus_req, m_pend);
      check("load_valid", load_valid, m_fin && !m_we);
      check("rdata", rdata, m_rdata);
      check("bus_we", bif.bus_we, m_we);
      check("bus_addr", bif.bus_addr, m_addr);
      check("bus_be", bif.bus_be, m_be);
      if (m_wd_known) check("bus_wdata", bif.bus_wdata, m_wd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request cycle, ack in BUSY cycle number ack_after, then observe through DONE
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rw, input int ack_after,
                            output int stall_cyc, output int err_cyc, output int lv_cyc,
                            output bit req_seen, output logic [31:0] rd_out,
                            output logic [3:0] be_out, output logic [31:0] wd_out,
                            output logic [31:0] ad_out);
    stall_cyc = 0; err_cyc = 0; lv_cyc = 0; req_seen = 0;
    rd_out = '0; be_out = '0; wd_out = '0; ad_out = '0;
    rd_en = rd; wr_en = wr; func3 = f3; addr = a; wdata = wd;
    for (int c = 0; c < ack_after + 3; c++) begin
      @(negedge clk);
      if (stall) stall_cyc++;
      if (lsu_err) err_cyc++;
      if (load_valid) begin lv_cyc++; rd_out = rdata; end
      if (bif.bus_req) begin
        req_seen = 1; be_out = bif.bus_be; wd_out = bif.bus_wdata; ad_out = bif.bus_addr;
      end
      tick();
      rd_en = 0; wr_en = 0;
      bif.bus_ack   = (c + 1 == ack_after);
      bif.bus_rdata = rw;
    end
    bif.bus_ack = 0;
  endtask

  int          sc, ec, lc;
  bit          rq;
  logic [31:0] ro, wo, ao;
  logic [3:0]  bo;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1; rd_en = 0; wr_en = 0; func3 = 0; addr = 0; wdata = 0;
    bif.bus_ack = 0; bif.bus_rdata = 0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_stall", stall, 0);
    check("reset_bus_req", bif.bus_req, 0);
    tick();
    rst = 0;
    @(negedge clk);
    check("post_reset_rdata", rdata, 0);
    check("post_reset_bus_be", bif.bus_be, 0);
    tick();

    // SB to 0x103, immediate ack
    run_access(0, 1, 3'b000, 32'h103, 32'h0000_00AB, 32'h0, 1, sc, ec, lc, rq, ro, bo, wo, ao);
    check("sb_be", bo, 4'b1000);
    check("sb_wdata", wo, 32'hABAB_ABAB);
    check("sb_addr", ao, 32'h100);
    check("sb_stall_cycles", sc, 2);
    check("sb_load_valid", lc, 0);

    // LH / LHU at 0x102, ack after 3 BUSY cycles
    run_access(1, 0, 3'b001, 32'h102, 32'h0, 32'h8001_1234, 3, sc, ec, lc, rq, ro, bo, wo, ao);
    check("lh_rdata", ro, 32'hFFFF_8001);
    check("lh_load_valid", lc, 1);
    check("lh_stall_cycles", sc, 4);
    check("lh_be", bo, 4'b1100);
    run_access(1, 0, 3'b101, 32'h102, 32'h0, 32'h8001_1234, 3, sc, ec, lc, rq, ro, bo, wo, ao);
    check("lhu_rdata", ro, 32'h0000_8001);

    // Byte loads and the remaining store sizes
    run_access(1, 0, 3'b000, 32'h103, 32'h0, 32'h7F00_0000, 2, sc, ec, lc, rq, ro, bo, wo, ao);
    check("lb_rdata", ro, 32'h0000_007F);
    run_access(1, 0, 3'b100, 32'h101, 32'h0, 32'h0000_F000, 1, sc, ec, lc, rq, ro, bo, wo, ao);
    check("lbu_rdata", ro, 32'h0000_00F0);
    run_access(0, 1, 3'b001, 32'h102, 32'h1234_ABCD, 32'h0, 2, sc, ec, lc, rq, ro, bo, wo, ao);
    check("sh_be", bo, 4'b1100);
    check("sh_wdata", wo, 32'hABCD_ABCD);
    run_access(0, 1, 3'b010, 32'h108, 32'hCAFE_F00D, 32'h0, 1, sc, ec, lc, rq, ro, bo, wo, ao);
    check("sw_be", bo, 4'b1111);
    check("sw_wdata", wo, 32'hCAFE_F00D);
    @(negedge clk);
    check("store_keeps_rdata", rdata, 32'h0000_00F0);
    tick();

    // Illegal requests; a stray ack while idle must be ignored
    run_access(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 1, sc, ec, lc, rq, ro, bo, wo, ao);
    check("misaligned_err_cycles", ec, 1);
    check("misaligned_no_req", rq, 0);
    check("misaligned_stall", sc, 0);
    run_access(1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 1, sc, ec, lc, rq, ro, bo, wo, ao);
    check("rdwr_err_cycles", ec, 1);
    check("rdwr_no_req", rq, 0);
    run_access(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 1, sc, ec, lc, rq, ro, bo, wo, ao);
    check("f3_011_err_cycles", ec, 1);
    check("f3_011_no_req", rq, 0);
    run_access(0, 1, 3'b001, 32'h101, 32'h0, 32'h0, 1, sc, ec, lc, rq, ro, bo, wo, ao);
    check("sh_misaligned_err", ec, 1);

    // Reset during the second BUSY cycle, ack arriving one cycle later
    rd_en = 1; func3 = 3'b010; addr = 32'h200;
    tick();
    rd_en = 0;
    tick();
    rst = 1;
    @(negedge clk);
    check("abort_req_in_rst", bif.bus_req, 0);
    check("abort_stall_in_rst", stall, 0);
    tick();
    rst = 0; bif.bus_ack = 1; bif.bus_rdata = 32'h5555_5555;
    @(negedge clk);
    check("abort_req_after", bif.bus_req, 0);
    check("abort_stall_after", stall, 0);
    check("abort_no_lv", load_valid, 0);
    tick();
    bif.bus_ack = 0;
    @(negedge clk);
    check("abort_late_no_lv", load_valid, 0);
    check("abort_rdata", rdata, 0);
    tick();

    // Back-to-back LB then SW; the store is held from the BUSY cycle onward
    ev.delete();
    rd_en = 1; func3 = 3'b000; addr = 32'h301;
    @(negedge clk);
    check("b2b_lb_accept_stall", stall, 1);
    tick();
    rd_en = 0; wr_en = 1; func3 = 3'b010; addr = 32'h304; wdata = 32'hDEAD_BEEF;
    bif.bus_ack = 1; bif.bus_rdata = 32'h1234_8056;
    @(negedge clk);
    check("b2b_busy_stall", stall, 1);
    tick();
    bif.bus_ack = 0;
    @(negedge clk);
    check("b2b_done_stall", stall, 0);
    check("b2b_done_lv", load_valid, 1);
    check("b2b_lb_rdata", rdata, 32'hFFFF_FF80);
    tick();
    @(negedge clk);
    check("b2b_sw_accept_stall", stall, 1);
    check("b2b_sw_accept_no_req", bif.bus_req, 0);
    tick();
    wr_en = 0; bif.bus_ack = 1;
    @(negedge clk);
    check("b2b_sw_we", bif.bus_we, 1);
    check("b2b_sw_addr", bif.bus_addr, 32'h304);
    check("b2b_sw_be", bif.bus_be, 4'b1111);
    tick();
    bif.bus_ack = 0;
    @(negedge clk);
    check("b2b_sw_no_lv", load_valid, 0);
    check("b2b_rdata_kept", rdata, 32'hFFFF_FF80);
    tick();
    @(negedge clk);
    check("b2b_event_count", ev.size(), 2);
    if (ev.size() == 2) begin
      check("b2b_first_event", ev[0], "L");
      check("b2b_second_event", ev[1], "W");
    end
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
